wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Round-robin arbiter that shares one write-back result bus (GPR, SPR or CR flavour) between NUM_REQ execution units.
- Each unit presents a valid/ready output bus of the same shape as the system unit's GPR bus: rs_id, reg_addr, result.
- Winner is captured into a registered output stage that drives the shared write-back bus toward the register file and reservation stations.
- One instance per bus type; REG_ADDR_WIDTH is 5 for GPR, 10 for SPR.

Parameters:
NUM_REQ, 4, number of requesting execution units (>=2)
RS_ID_WIDTH, 5, reservation-station tag width
REG_ADDR_WIDTH, 5, destination register address width
DATA_WIDTH, 32, result width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester result valid
req_ready  out  NUM_REQ  per-requester accept (grant)
req_rs_id  in  NUM_REQ*RS_ID_WIDTH  tags; requester i at slice i (MSB-first, index 0 leftmost)
req_reg_addr  in  NUM_REQ*REG_ADDR_WIDTH  destination addresses, same slicing
req_result  in  NUM_REQ*DATA_WIDTH  result data, same slicing
out_valid  out  1  shared bus valid
out_ready  in  1  shared bus consumer ready
out_rs_id  out  RS_ID_WIDTH  tag of granted result
out_reg_addr  out  REG_ADDR_WIDTH  destination of granted result
out_result  out  DATA_WIDTH  granted result
out_grant_id  out  clog2(NUM_REQ)  index of requester that produced current output

Behaviour:
- Reset:
  - The only asynchronous reset in the block; it uses a separate always_ff sensitive to posedge clk or posedge rst.
  - Asserting rst immediately clears out_valid, out_rs_id, out_reg_addr, out_result, out_grant_id and priority pointer ptr to 0.
  - req_ready is 0 while rst is high.
- Load enable: load_en = !out_valid || out_ready. Output stage is a single register; no internal FIFO.
- Arbitration (combinational):
  - When load_en=1, the winner g is the first i with req_valid[i]=1, scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready[g]=1; every other req_ready bit is 0.
  - When load_en=0, all req_ready are 0.
  - req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
- Transfer on clock edge:
  - Requester g hands off when req_valid[g] && req_ready[g].
  - Next cycle: out_valid=1, out_* = slice g, out_grant_id=g, ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle from handshake to out_valid.
- Idle: load_en=1 and no req_valid gives out_valid <= 0; ptr unchanged; out_* data hold their last value (don't-care).
- Stall: out_valid=1 and out_ready=0 holds out_* stable and asserts no grant; ptr unchanged.
- Throughput: with out_ready held at 1, one result per cycle. Back-to-back consume and reload in the same edge is required.
- Wrap-around: a grant to NUM_REQ-1 sets ptr to 0. Non-power-of-two NUM_REQ must wrap correctly, never producing an index >= NUM_REQ.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Reset mid-operation: the in-flight output is dropped, with no replay. Requesters holding valid are re-arbitrated from ptr=0 on the first edge after rst deasserts.

Decomposition:
- Shared package ppc_types gains:
  - wb_bus_t struct {rs_id, reg_addr, result}, used for GPR width;
  - constant WB_GPR_ADDR_WIDTH=5;
  - constant WB_SPR_ADDR_WIDTH=10.
- One sub-module, rr_priority_select (NUM_REQ):
  - inputs: request vector, ptr, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational, reused later by the dispatch scheduler.

Test Plan:
- Single requester: NUM_REQ=4, req_valid=0010, result 0xDEADBEEF, rs_id 3, out_ready=1. Expect req_ready=0010 the same cycle; next cycle out_valid=1, out_result=0xDEADBEEF, out_rs_id=3, out_grant_id=1; ptr becomes 2.
- Round-robin: req_valid=1111 held 8 cycles, out_ready=1. Expect grant order 0,1,2,3,0,1,2,3 and out_valid=1 every cycle from cycle 1.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles and req_valid=1111. Expect req_ready=0000 and out_* unchanged throughout. On out_ready=1, the next winner (ptr) loads in the same edge.
- Wrap and skip: ptr=3, req_valid=0101. Expect grant 0, then 2, then 0; out_grant_id never exceeds 3. Repeat with NUM_REQ=3 and req_valid=111: order 0,1,2,0.
- Async reset mid-stall: out_valid=1 and out_ready=0, pulse rst between clock edges. Expect out_valid=0 immediately (before next edge), req_ready=0 during rst. After release with req_valid=1000, requester 3 is granted and ptr becomes 0.
- Idle: req_valid=0000 with out_ready=1 for 3 cycles. Expect out_valid=0 and ptr unchanged.

Source files
------------

// File: rtl/ppc_types.sv
// Shared types for the PPC core: write-back bus shape and widths.
// Also hosts small helpers shared across arbitration logic.
package ppc_types;

   localparam int WB_GPR_ADDR_WIDTH = 5;
   localparam int WB_SPR_ADDR_WIDTH = 10;
   localparam int WB_RS_ID_WIDTH    = 5;
   localparam int WB_DATA_WIDTH     = 32;

   typedef struct packed {
      logic [WB_RS_ID_WIDTH-1:0]    rs_id;
      logic [WB_GPR_ADDR_WIDTH-1:0] reg_addr;
      logic [WB_DATA_WIDTH-1:0]     result;
   } wb_bus_t;

   // Round-robin successor of idx in a ring of n slots.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority selector: first active request at or after ptr.
// Purely combinational; ptr must be below NUM_REQ.
module rr_priority_select #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx,
   output logic               found
);

   int j;

   // Scan ptr, ptr+1, ... with modulo wrap; first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (en && !found && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one write-back bus among execution units.
// Winner lands in a single registered output stage; no queueing.
module wb_bus_arbiter
   import ppc_types::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int RS_ID_WIDTH    = WB_RS_ID_WIDTH,
   parameter int REG_ADDR_WIDTH = WB_GPR_ADDR_WIDTH,
   parameter int DATA_WIDTH     = WB_DATA_WIDTH,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*RS_ID_WIDTH-1:0]    req_rs_id,
   input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_reg_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_result,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [RS_ID_WIDTH-1:0]            out_rs_id,
   output logic [REG_ADDR_WIDTH-1:0]         out_reg_addr,
   output logic [DATA_WIDTH-1:0]             out_result,
   output logic [IW-1:0]                     out_grant_id
);

   logic [IW-1:0]             ptr;
   logic                      load_en;
   logic                      sel_en;
   logic [NUM_REQ-1:0]        grant;
   logic [IW-1:0]             gidx;
   logic                      found;
   logic [RS_ID_WIDTH-1:0]    sel_rs_id;
   logic [REG_ADDR_WIDTH-1:0] sel_reg_addr;
   logic [DATA_WIDTH-1:0]     sel_result;
   int                        sl;

   assign load_en   = !out_valid || out_ready;
   assign sel_en    = load_en && !rst;
   assign req_ready = grant;

   rr_priority_select #(.NUM_REQ(NUM_REQ)) u_sel (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (sel_en),
      .grant (grant),
      .idx   (gidx),
      .found (found)
   );

   // Pick the winner's fields; requester 0 sits in the top slice.
   always_comb begin
      sl           = NUM_REQ - 1 - int'(gidx);
      sel_rs_id    = req_rs_id[sl*RS_ID_WIDTH +: RS_ID_WIDTH];
      sel_reg_addr = req_reg_addr[sl*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      sel_result   = req_result[sl*DATA_WIDTH +: DATA_WIDTH];
   end

   // Output stage and priority pointer; reload whenever slot frees.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_rs_id    <= '0;
         out_reg_addr <= '0;
         out_result   <= '0;
         out_grant_id <= '0;
         ptr          <= '0;
      end else if (load_en) begin
         out_valid <= found;
         if (found) begin
            out_rs_id    <= sel_rs_id;
            out_reg_addr <= sel_reg_addr;
            out_result   <= sel_result;
            out_grant_id <= gidx;
            ptr          <= IW'(rr_next(int'(gidx), NUM_REQ));
         end
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (4-way and 3-way instances).
// Expected values are hand-derived constants per step.
module tb_wb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  v4;
   logic [3:0]  rdy4;
   logic [19:0] rs4;
   logic [19:0] ra4;
   logic [127:0] dat4;
   logic        ov4;
   logic        ordy4;
   logic [4:0]  ors4;
   logic [4:0]  ora4;
   logic [31:0] odat4;
   logic [1:0]  ogid4;

   logic [2:0]  v3;
   logic [2:0]  rdy3;
   logic [14:0] rs3;
   logic [14:0] ra3;
   logic [95:0] dat3;
   logic        ov3;
   logic        ordy3;
   logic [4:0]  ors3;
   logic [4:0]  ora3;
   logic [31:0] odat3;
   logic [1:0]  ogid3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_bus_arbiter #(.NUM_REQ(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (v4),
      .req_ready    (rdy4),
      .req_rs_id    (rs4),
      .req_reg_addr (ra4),
      .req_result   (dat4),
      .out_valid    (ov4),
      .out_ready    (ordy4),
      .out_rs_id    (ors4),
      .out_reg_addr (ora4),
      .out_result   (odat4),
      .out_grant_id (ogid4)
   );

   wb_bus_arbiter #(.NUM_REQ(3)) dut3 (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (v3),
      .req_ready    (rdy3),
      .req_rs_id    (rs3),
      .req_reg_addr (ra3),
      .req_result   (dat3),
      .out_valid    (ov3),
      .out_ready    (ordy3),
      .out_rs_id    (ors3),
      .out_reg_addr (ora3),
      .out_result   (odat3),
      .out_grant_id (ogid3)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set4(input int i, input logic [4:0] rs,
                       input logic [4:0] ra, input logic [31:0] d);
      rs4[(3-i)*5 +: 5]    = rs;
      ra4[(3-i)*5 +: 5]    = ra;
      dat4[(3-i)*32 +: 32] = d;
   endtask

   task automatic set3(input int i, input logic [4:0] rs,
                       input logic [4:0] ra, input logic [31:0] d);
      rs3[(2-i)*5 +: 5]    = rs;
      ra3[(2-i)*5 +: 5]    = ra;
      dat3[(2-i)*32 +: 32] = d;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      v4    = 4'hF;
      rs4   = '0;
      ra4   = '0;
      dat4  = '0;
      ordy4 = 1'b1;
      v3    = '0;
      rs3   = '0;
      ra3   = '0;
      dat3  = '0;
      ordy3 = 1'b1;

      // reset state, ready gated while rst high
      #2;
      chk("rst_ready", 64'(rdy4), 64'h0);
      chk("rst_valid", 64'(ov4), 64'h0);
      chk("rst_gid", 64'(ogid4), 64'h0);
      chk("rst_ptr", 64'(dut.ptr), 64'h0);
      v4 = 4'h0;
      edge1();
      rst = 1'b0;

      // single requester 1
      set4(1, 5'd3, 5'd7, 32'hDEADBEEF);
      v4 = 4'b0010;
      #1;
      chk("single_ready", 64'(rdy4), 64'h2);
      edge1();
      chk("single_valid", 64'(ov4), 64'h1);
      chk("single_data", 64'(odat4), 64'hDEADBEEF);
      chk("single_rs", 64'(ors4), 64'h3);
      chk("single_ra", 64'(ora4), 64'h7);
      chk("single_gid", 64'(ogid4), 64'h1);
      chk("single_ptr", 64'(dut.ptr), 64'h2);
      v4 = 4'h0;

      // idle: nothing valid for 3 cycles
      for (int k = 0; k < 3; k++) begin
         edge1();
         chk("idle_valid", 64'(ov4), 64'h0);
         chk("idle_ptr", 64'(dut.ptr), 64'h2);
      end

      // distinct payloads per requester
      for (int i = 0; i < 4; i++)
         set4(i, 5'(10 + i), 5'(20 + i), 32'h1000_0000 + 32'(i));

      // move ptr to 0 via requester 3
      v4 = 4'b1000;
      edge1();
      chk("to0_gid", 64'(ogid4), 64'h3);
      chk("to0_ptr", 64'(dut.ptr), 64'h0);

      // round robin, all valid, one result per cycle
      v4 = 4'hF;
      #1;
      chk("rr_ready0", 64'(rdy4), 64'h1);
      for (int k = 0; k < 8; k++) begin
         edge1();
         chk("rr_valid", 64'(ov4), 64'h1);
         chk("rr_gid", 64'(ogid4), 64'(k % 4));
         chk("rr_data", 64'(odat4), 64'h1000_0000 + 64'(k % 4));
         chk("rr_rs", 64'(ors4), 64'(10 + k % 4));
      end

      // backpressure holds output, no grants
      ordy4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready", 64'(rdy4), 64'h0);
         edge1();
         chk("bp_valid", 64'(ov4), 64'h1);
         chk("bp_gid", 64'(ogid4), 64'h3);
         chk("bp_data", 64'(odat4), 64'h1000_0003);
      end
      ordy4 = 1'b1;
      #1;
      chk("bp_rel_ready", 64'(rdy4), 64'h1);
      edge1();
      chk("bp_rel_gid", 64'(ogid4), 64'h0);
      chk("bp_rel_data", 64'(odat4), 64'h1000_0000);
      chk("bp_rel_ptr", 64'(dut.ptr), 64'h1);

      // wrap and skip
      v4 = 4'b0100;
      edge1();
      chk("ws_gid2", 64'(ogid4), 64'h2);
      chk("ws_ptr3", 64'(dut.ptr), 64'h3);
      v4 = 4'b0101;
      edge1();
      chk("ws_gid_a", 64'(ogid4), 64'h0);
      edge1();
      chk("ws_gid_b", 64'(ogid4), 64'h2);
      edge1();
      chk("ws_gid_c", 64'(ogid4), 64'h0);
      chk("ws_ptr1", 64'(dut.ptr), 64'h1);

      // async reset during a stall
      ordy4 = 1'b0;
      v4    = 4'b1000;
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(ov4), 64'h0);
      chk("ar_gid", 64'(ogid4), 64'h0);
      chk("ar_data", 64'(odat4), 64'h0);
      chk("ar_ptr", 64'(dut.ptr), 64'h0);
      chk("ar_ready", 64'(rdy4), 64'h0);
      #1;
      rst   = 1'b0;
      ordy4 = 1'b1;
      #1;
      chk("ar_rel_ready", 64'(rdy4), 64'h8);
      edge1();
      chk("ar_rel_valid", 64'(ov4), 64'h1);
      chk("ar_rel_gid", 64'(ogid4), 64'h3);
      chk("ar_rel_data", 64'(odat4), 64'h1000_0003);
      chk("ar_rel_ptr", 64'(dut.ptr), 64'h0);
      v4 = 4'h0;

      // three-way instance wraps 0,1,2,0
      for (int i = 0; i < 3; i++)
         set3(i, 5'(i + 1), 5'(i + 4), 32'h0000_00A0 + 32'(i));
      v3 = 3'b111;
      #1;
      chk("n3_ready0", 64'(rdy3), 64'h1);
      for (int k = 0; k < 4; k++) begin
         edge1();
         chk("n3_valid", 64'(ov3), 64'h1);
         chk("n3_gid", 64'(ogid3), 64'(k % 3));
         chk("n3_data", 64'(odat3), 64'hA0 + 64'(k % 3));
      end
      chk("n3_ptr", 64'(dut3.ptr), 64'h1);
      v3 = 3'b000;
      edge1();
      chk("n3_idle", 64'(ov3), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
